alu_md: RTL and testbench

Parametrised execute unit that extends the base RV32I integer ALU with the RV32M multiply/divide operations. It has a valid/ready handshake on input and output, and a registered result. Single-cycle operations complete in one clock. Division, and multiplication when the fast multiplier is compiled out, run iteratively and hold off new operations while busy. It sits in the execute stage between decode/operand fetch and memory. Its `busy`/`in_ready` drive the pipeline stall.

---
 rtl/alu_md.sv | 176 +++++++++++++++++
 tb/tb_alu_md.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// RV32I ALU extended with RV32M multiply/divide: valid/ready in, registered result out.
// Define ALU_MD_FAST_MUL_EN for a one-cycle combinational multiplier; otherwise multiply is iterative.
module alu_md #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal_op,
    output logic            busy
);

    // state | meaning
    // IDLE  | accepting ops; single-cycle ops are written to the result register on accept
    // BUSY  | iterative divide (or multiply) running, one bit per cycle; cnt counts down to 0

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_OR  = 5'd5,  OP_AND = 5'd6,  OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

    state_t          state, state_nx;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] acc_hi, acc_lo, opnd;
    logic            neg_q, neg_r, sel_hi, it_mul;

    logic            is_mul, is_div, is_ill, div_zero, div_ovf, iter_op, accept;
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag, min_val, fast_res, iter_res;
    logic [SHW-1:0]  shamt;

    assign min_val  = {1'b1, {(XLEN-1){1'b0}}};
    assign shamt    = op_b[SHW-1:0];
    assign is_mul   = (op >= OP_MUL) && (op <= OP_MULHU);
    assign is_div   = (op >= OP_DIV) && (op <= OP_REMU);
    assign is_ill   = (op > OP_REMU);
    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (op_a == min_val) && (op_b == '1);

`ifdef ALU_MD_FAST_MUL_EN
    assign iter_op  = is_div && !div_zero && !div_ovf;
`else
    assign iter_op  = (is_div && !div_zero && !div_ovf) || is_mul;
`endif

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign busy     = (state == BUSY);

    // Signed ops work on magnitudes; signs are reapplied when the iteration finishes.
    assign a_sgn = op_a[XLEN-1] && ((op == OP_DIV) || (op == OP_REM) || (op == OP_MULH) || (op == OP_MULHSU));
    assign b_sgn = op_b[XLEN-1] && ((op == OP_DIV) || (op == OP_REM) || (op == OP_MULH));
    assign a_mag = a_sgn ? -op_a : op_a;
    assign b_mag = b_sgn ? -op_b : op_b;

`ifdef ALU_MD_FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
    assign a_ext     = {{XLEN{a_sgn}}, op_a};
    assign b_ext     = {{XLEN{b_sgn}}, op_b};
    assign fast_prod = a_ext * b_ext;
`endif

    always_comb begin
        fast_res = '0;
        case (op)
            OP_ADD:  fast_res = op_a + op_b;
            OP_SUB:  fast_res = op_a - op_b;
            OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  fast_res = op_a ^ op_b;
            OP_OR:   fast_res = op_a | op_b;
            OP_AND:  fast_res = op_a & op_b;
            OP_SLL:  fast_res = op_a << shamt;
            OP_SRL:  fast_res = op_a >> shamt;
            OP_SRA:  fast_res = $signed(op_a) >>> shamt;
`ifdef ALU_MD_FAST_MUL_EN
            OP_MUL:  fast_res = fast_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fast_res = fast_prod[2*XLEN-1:XLEN];
`endif
            OP_DIV, OP_DIVU: fast_res = div_zero ? '1 : min_val;
            OP_REM, OP_REMU: fast_res = div_zero ? op_a : '0;
            default: fast_res = '0;
        endcase
    end

    // Shared datapath: divide uses acc_hi=remainder, acc_lo=dividend/quotient;
    // multiply uses {acc_hi, acc_lo} as the shifting product with the multiplier in acc_lo.
    logic [XLEN:0]     shifted, diff, sum;
    logic [XLEN-1:0]   hi_nx, lo_nx, q_fix, r_fix;
    logic [2*XLEN-1:0] prod, prod_s;

    assign shifted = {acc_hi, acc_lo[XLEN-1]};
    assign diff    = shifted - {1'b0, opnd};
    assign sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign hi_nx   = it_mul ? sum[XLEN:1] : (diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]);
    assign lo_nx   = it_mul ? {sum[0], acc_lo[XLEN-1:1]} : {acc_lo[XLEN-2:0], ~diff[XLEN]};
    assign prod    = {hi_nx, lo_nx};
    assign prod_s  = neg_q ? -prod : prod;
    assign q_fix   = neg_q ? -lo_nx : lo_nx;
    assign r_fix   = neg_r ? -hi_nx : hi_nx;
    assign iter_res = it_mul ? (sel_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0])
                             : (sel_hi ? r_fix : q_fix);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && iter_op) state_nx = BUSY;
            BUSY:    if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opnd       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            sel_hi     <= 1'b0;
            it_mul     <= 1'b0;
            result     <= '0;
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state <= state_nx;
            if (flush) begin
                out_valid  <= 1'b0;
                illegal_op <= 1'b0;
            end else if (accept) begin
                illegal_op <= is_ill;
                if (iter_op) begin
                    out_valid <= 1'b0;
                    cnt       <= SHW'(XLEN-1);
                    acc_hi    <= '0;
                    acc_lo    <= is_mul ? b_mag : a_mag;
                    opnd      <= is_mul ? a_mag : b_mag;
                    neg_q     <= a_sgn ^ b_sgn;
                    neg_r     <= a_sgn;
                    sel_hi    <= (op == OP_REM) || (op == OP_REMU) || (op == OP_MULH) ||
                                 (op == OP_MULHSU) || (op == OP_MULHU);
                    it_mul    <= is_mul;
                end else begin
                    out_valid <= 1'b1;
                    result    <= fast_res;
                end
            end else if (state == BUSY) begin
                acc_hi <= hi_nx;
                acc_lo <= lo_nx;
                cnt    <= cnt - 1'b1;
                if (cnt == '0) begin
                    out_valid <= 1'b1;
                    result    <= iter_res;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed corner cases plus randomized traffic
// against a transaction-level model (ideal arithmetic + fixed latency per op class).
module tb_alu_md;
    localparam int XLEN = 32;
`ifdef ALU_MD_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic        clk = 1'b0, rstn = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        in_ready, out_valid, illegal_op, busy;
    logic [31:0] result;

    always #5 clk = ~clk;

    alu_md #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .illegal_op(illegal_op), .busy(busy)
    );

    int n_tests = 0, n_fail = 0;

    // Model state: what the output register must hold, and cycles left of a long op.
    bit          m_ov, m_ill;
    logic [31:0] m_res, m_pend;
    int          m_left;

    function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] pu;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return {31'b0, $signed(a) < $signed(b)};
            5'd3:  return {31'b0, a < b};
            5'd4:  return a ^ b;
            5'd5:  return a | b;
            5'd6:  return a & b;
            5'd7:  return a << b[4:0];
            5'd8:  return a >> b[4:0];
            5'd9:  return 32'($signed(a) >>> b[4:0]);
            5'd10: begin p = sa * sb; return p[31:0]; end
            5'd11: begin p = sa * sb; return p[63:32]; end
            5'd12: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            5'd13: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            5'd14: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd16: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            5'd17: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_single(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o <= 9 || o > 17) return 1'b1;
        if (o <= 13) return FAST_MUL;
        if (b == 0) return 1'b1;
        if ((o == 14 || o == 16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov = 1'b0; m_ill = 1'b0; m_res = '0; m_pend = '0; m_left = 0;
    endtask

    // One clock: check registered outputs, drive inputs, check in_ready, advance the model.
    task automatic step(input bit iv, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit fl, input bit ordy);
        bit exp_rdy, acc;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        if (m_ov) chk("result", result, m_res);
        in_valid = iv; op = o; op_a = a; op_b = b; flush = fl; out_ready = ordy;
        #1;
        exp_rdy = (m_left == 0) && (!m_ov || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = iv && exp_rdy && !fl;
        if (fl) begin
            m_ov = 1'b0; m_ill = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_ov = 1'b1; m_res = m_pend; end
        end else begin
            if (m_ov && ordy) m_ov = 1'b0;
            if (acc) begin
                m_ill = (o > 17);
                if (is_single(o, a, b)) begin
                    m_ov = 1'b1; m_res = ref_res(o, a, b);
                end else begin
                    m_ov = 1'b0; m_left = XLEN; m_pend = ref_res(o, a, b);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mul_lat;
        mul_lat = FAST_MUL ? 1 : XLEN + 1;
        model_reset();

        // Hand-computed values pin the model itself.
        chk("model ADD", ref_res(5'd0, 32'h7FFF_FFFF, 32'h1), 32'h8000_0000);
        chk("model SRA", ref_res(5'd9, 32'h8000_0000, 32'h21), 32'hC000_0000);
        chk("model DIV", ref_res(5'd14, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
        chk("model REM", ref_res(5'd16, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        chk("model MULH", ref_res(5'd11, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("model MULHSU", ref_res(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model MULHU", ref_res(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

        #12;
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst illegal_op", 32'(illegal_op), 32'h0);
        chk("rst result", result, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'h1);

        step(1'b1, 5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        peek();
        chk("ADD N+1 valid", 32'(out_valid), 32'h1);
        chk("ADD result", result, 32'h8000_0000);

        step(1'b1, 5'd9, 32'h8000_0000, 32'h21, 1'b0, 1'b1);
        peek();
        chk("SRA result", result, 32'hC000_0000);

        step(1'b1, 5'd14, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b1);
        peek();
        chk("DIV N+1 busy", 32'(busy), 32'h1);
        chk("DIV N+1 no valid", 32'(out_valid), 32'h0);
        idle(XLEN);
        peek();
        chk("DIV N+33 valid", 32'(out_valid), 32'h1);
        chk("DIV result", result, 32'hFFFF_FFFD);
        step(1'b1, 5'd16, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b1);
        idle(XLEN);
        peek();
        chk("REM result", result, 32'hFFFF_FFFF);

        step(1'b1, 5'd15, 32'h5, 32'h0, 1'b0, 1'b1);
        peek();
        chk("DIVU/0 N+1 valid", 32'(out_valid), 32'h1);
        chk("DIVU/0 result", result, 32'hFFFF_FFFF);
        step(1'b1, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        peek();
        chk("REM ovf N+1 valid", 32'(out_valid), 32'h1);
        chk("REM ovf result", result, 32'h0);

        step(1'b1, 5'd11, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        idle(mul_lat - 1);
        peek();
        chk("MULH latency valid", 32'(out_valid), 32'h1);
        chk("MULH result", result, 32'h4000_0000);

        step(1'b1, 5'd15, 32'h100, 32'h7, 1'b0, 1'b1);
        idle(9);
        step(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        peek();
        chk("flush busy", 32'(busy), 32'h0);
        chk("flush out_valid", 32'(out_valid), 32'h0);
        idle(XLEN + 8);

        step(1'b1, 5'd0, 32'h3, 32'h4, 1'b0, 1'b0);
        step(1'b1, 5'd1, 32'h9, 32'h9, 1'b0, 1'b0);
        peek();
        chk("bp in_ready", 32'(in_ready), 32'h0);
        chk("bp result held", result, 32'h7);
        step(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);

        step(1'b1, 5'd20, 32'h1234, 32'h5678, 1'b0, 1'b1);
        peek();
        chk("illegal flag", 32'(illegal_op), 32'h1);
        chk("illegal result", result, 32'h0);
        step(1'b1, 5'd0, 32'h1, 32'h1, 1'b0, 1'b1);
        peek();
        chk("illegal cleared", 32'(illegal_op), 32'h0);

        step(1'b1, 5'd14, 32'h100, 32'h3, 1'b0, 1'b1);
        idle(5);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst result", result, 32'h0);
        chk("midrst in_ready", 32'(in_ready), 32'h1);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] o;
            o = 5'($urandom_range(0, 19));
            step($urandom_range(0, 9) < 7, o, pick_operand(), pick_operand(),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
        end
        idle(XLEN + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
